// File: rtl/alu_iterativa.sv
// RV32I execution unit: single-cycle arithmetic/logic ops and a 1-bit-per-cycle
// serial shifter behind an inicio/listo request handshake.
module alu_iterativa #(
  parameter int unsigned ANCHO      = 32,
  parameter int unsigned BITS_SHAMT = 5
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             inicio,
  output logic             listo,
  input  logic [3:0]       sel_alu,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  output logic [ANCHO-1:0] resultado,
  output logic             cero,
  output logic             valido
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLL  = 4'b0010,
    OP_SLT  = 4'b0011,
    OP_SLTU = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_OR   = 4'b1000,
    OP_AND  = 4'b1001
  } op_e;

  typedef enum logic {
    REPOSO,
    DESPLAZA
  } estado_e;

  estado_e               estado;
  op_e                   op_desp;
  logic [ANCHO-1:0]      desp;
  logic [BITS_SHAMT-1:0] cuenta;

  logic [ANCHO-1:0]      res_comb;
  logic [ANCHO-1:0]      desp_sig;
  logic [BITS_SHAMT-1:0] shamt;
  logic                  es_desp;

  assign listo   = (estado == REPOSO);
  assign shamt   = b[BITS_SHAMT-1:0];
  assign es_desp = (sel_alu == OP_SLL) || (sel_alu == OP_SRL) || (sel_alu == OP_SRA);

  // Shift codes fall through to 'a' so a zero shamt completes on the single-cycle path.
  always_comb begin
    res_comb = '0;
    case (sel_alu)
      OP_ADD:  res_comb = a + b;
      OP_SUB:  res_comb = a + ~b + ANCHO'(1);
      OP_SLT:  res_comb = {{(ANCHO-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res_comb = {{(ANCHO-1){1'b0}}, (a < b)};
      OP_XOR:  res_comb = a ^ b;
      OP_OR:   res_comb = a | b;
      OP_AND:  res_comb = a & b;
      OP_SLL,
      OP_SRL,
      OP_SRA:  res_comb = a;
      default: res_comb = '0;
    endcase
  end

  always_comb begin
    desp_sig = desp;
    case (op_desp)
      OP_SLL:  desp_sig = {desp[ANCHO-2:0], 1'b0};
      OP_SRL:  desp_sig = {1'b0, desp[ANCHO-1:1]};
      default: desp_sig = {desp[ANCHO-1], desp[ANCHO-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      estado    <= REPOSO;
      op_desp   <= OP_SRA;
      desp      <= '0;
      cuenta    <= '0;
      resultado <= '0;
      cero      <= 1'b1;
      valido    <= 1'b0;
    end else begin
      valido <= 1'b0;
      case (estado)
        REPOSO: begin
          if (inicio) begin
            if (es_desp && (shamt != '0)) begin
              desp    <= a;
              cuenta  <= shamt;
              op_desp <= op_e'(sel_alu);
              estado  <= DESPLAZA;
            end else begin
              resultado <= res_comb;
              cero      <= (res_comb == '0);
              valido    <= 1'b1;
            end
          end
        end
        DESPLAZA: begin
          desp   <= desp_sig;
          cuenta <= cuenta - BITS_SHAMT'(1);
          if (cuenta == BITS_SHAMT'(1)) begin
            resultado <= desp_sig;
            cero      <= (desp_sig == '0);
            valido    <= 1'b1;
            estado    <= REPOSO;
          end
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: doc/alu_iterativa.md
Name: alu_iterativa

Overview:
- 32-bit RV32I execution unit directly downstream of control_alu; consumes its 4-bit sel_alu code plus two operands and returns a registered result with a completion pulse.
- Arithmetic and logic ops complete in one cycle; shifts (SLL/SRL/SRA) use a 1-bit-per-cycle serial shifter to save area, so latency is variable and a start/ready handshake is required.
- Also produces the zero flag consumed by branch resolution (BEQ/BNE via SUB, BLT/BGE via SLT, BLTU/BGEU via SLTU).

Parameters:
- ANCHO, 32, datapath width in bits; fixed at 32 for RV32I.
- BITS_SHAMT, 5, width of the shift amount taken from b[4:0].

Ports:
- clk  input  1  system clock, rising edge.
- nreset  input  1  asynchronous active-low reset.
- inicio  input  1  request: operands and sel_alu are valid this cycle.
- listo  output  1  unit idle; a request is accepted when inicio && listo.
- sel_alu  input  4  operation code from control_alu.
- a  input  32  operand A (rs1).
- b  input  32  operand B (rs2 or immediate); b[4:0] is shamt for shifts.
- resultado  output  32  registered result; holds until the next completion.
- cero  output  1  registered (resultado == 0), updated with resultado.
- valido  output  1  one-cycle pulse: resultado/cero updated this cycle.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (ports clk, nreset). Asserting nreset=0 forces state REPOSO, listo=1, valido=0, resultado=0, cero=1, and clears the shift counter. Any operation in progress is aborted with no valido.
- sel_alu encoding:
  - 0000 ADD
  - 0001 SUB
  - 0010 SLL
  - 0011 SLT (signed, result 0/1)
  - 0100 SLTU
  - 0101 XOR
  - 0110 SRL
  - 0111 SRA
  - 1000 OR
  - 1001 AND
  - 1010–1111: result 0, single-cycle, no error.
- Arithmetic: modulo 2^32, no overflow or carry outputs; SUB is a + ~b + 1.
- States: REPOSO, DESPLAZA. listo = (state == REPOSO).
- REPOSO, accept edge, non-shift op or shift with shamt=0: register the result (shamt=0 returns a unchanged) and set valido=1 on the following cycle; stay in REPOSO. Latency is 1 cycle.
- REPOSO, accept edge, shift with shamt=N>0: latch a into the shift register, counter=N, latch the op, go to DESPLAZA.
- DESPLAZA, each edge: shift 1 bit (SLL inserts 0 at LSB; SRL inserts 0 at MSB; SRA replicates bit 31), counter-1. On the edge where counter goes 1→0: resultado=shift register, valido=1, return to REPOSO.
- Shift latency: valido is high exactly N cycles after the accept edge (N in 1..31).
- inicio while listo=0 is ignored; sel_alu, a and b are not sampled and need not be held after acceptance.
- Back-to-back: listo=1 in the same cycle valido=1, so a new request can be accepted on the cycle after any completion.
- valido is never high for two consecutive cycles from one request. resultado/cero change only on cycles where valido=1.

Test Plan:
- Reset mid-shift: SLL a=1, b=31, then nreset=0 at cycle 10 → no valido, resultado=0, cero=1, listo=1 immediately (asynchronous).
- Single-cycle ops: ADD 0x7FFFFFFF+1 → 0x80000000; SUB 5-5 → 0, cero=1; SLT 0xFFFFFFFF vs 1 → 1; SLTU same → 0. Each gives valido 1 cycle after accept.
- Shifts: SRA 0x80000000 by 4 → 0xF8000000 with valido 4 cycles after accept; SRL same → 0x08000000; SLL 0x1 by 31 → 0x80000000 at 31 cycles; listo=0 throughout.
- Shamt boundaries: SLL b=0x00000020 (shamt 0) → resultado=a after 1 cycle; SRA b=0xFFFFFFE1 (shamt 1) → 1 cycle.
- Handshake: hold inicio=1 with a new ADD while a 10-cycle SRL is running → ADD accepted only on the valido cycle's edge; its valido comes 1 cycle later; exactly two valido pulses in total.
- Unused codes: sel_alu=1100, a=b=0xFFFFFFFF → resultado=0, cero=1, valido after 1 cycle.
